// File: rtl/reset_sequencer_multi_if.sv
// Handshake bundle between the reset sequencer and the logic it brings out of reset.
// The slave modport is the sequencer side; master is the consumer side.
interface reset_sequencer_multi_if #(
  parameter int NUM_STAGES = 4
);
  localparam int IDX_W = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;

  logic                  restart;
  logic [NUM_STAGES-1:0] stage_rdy;
  logic [NUM_STAGES-1:0] rst_out;
  logic [IDX_W-1:0]      stage_idx;
  logic                  done;
  logic                  timeout_err;

  modport master (
    output restart, stage_rdy,
    input  rst_out, stage_idx, done, timeout_err
  );

  modport slave (
    input  restart, stage_rdy,
    output rst_out, stage_idx, done, timeout_err
  );
endinterface

// File: rtl/reset_sequencer_multi.sv
// Staged reset release: NUM_STAGES active-high resets freed in ascending order after per-stage holds.
// Define RST_SEQ_TIMEOUT_EN to add the sticky ready-wait timeout; without it WAIT persists forever.
//   state   | meaning
//   S_COUNT | counting hold cycles of stage stage_idx
//   S_WAIT  | stage stage_idx released, waiting for its stage_rdy
//   S_DONE  | every stage released, done asserted
module reset_sequencer_multi #(
  parameter int                          NUM_STAGES = 4,
  parameter int                          CNT_W      = 10,
  parameter logic [NUM_STAGES*CNT_W-1:0] STAGE_DLY  = {4{10'd100}},
  parameter logic [NUM_STAGES-1:0]       WAIT_RDY   = 4'b0100,
  parameter logic [15:0]                 TIMEOUT    = 16'd1000
) (
  input logic                    clk10m,
  input logic                    sys_rst_n,
  reset_sequencer_multi_if.slave bus
);
  localparam int               IDX_W    = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;
  localparam int               DEPTH    = 1 << IDX_W;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_STAGES - 1);

  typedef enum logic [1:0] {S_COUNT, S_WAIT, S_DONE} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;

  // Tables padded to a power of two so any stage_idx value indexes safely.
  logic [CNT_W-1:0] dly_tab [DEPTH];
  logic [DEPTH-1:0] wait_tab;
  logic [DEPTH-1:0] rdy_tab;
  logic [DEPTH-1:0] legal_tab;

  for (genvar i = 0; i < DEPTH; i++) begin : g_tab
    if (i < NUM_STAGES) begin : g_used
      assign dly_tab[i]   = STAGE_DLY[i*CNT_W +: CNT_W];
      assign wait_tab[i]  = WAIT_RDY[i];
      assign rdy_tab[i]   = bus.stage_rdy[i];
      assign legal_tab[i] = 1'b1;
    end else begin : g_pad
      assign dly_tab[i]   = '0;
      assign wait_tab[i]  = 1'b0;
      assign rdy_tab[i]   = 1'b0;
      assign legal_tab[i] = 1'b0;
    end
  end

  logic                  is_last;
  logic [NUM_STAGES-1:0] release_mask;

  assign is_last      = (bus.stage_idx == LAST_IDX);
  assign release_mask = ~(NUM_STAGES'(1) << bus.stage_idx);

`ifdef RST_SEQ_TIMEOUT_EN
  logic [15:0] wait_cnt;
`else
  assign bus.timeout_err = 1'b0;
`endif

  always_ff @(posedge clk10m) begin
    if (!sys_rst_n || bus.restart || !legal_tab[bus.stage_idx]) begin
      state         <= S_COUNT;
      bus.stage_idx <= '0;
      cnt           <= '0;
      bus.rst_out   <= '1;
      bus.done      <= 1'b0;
`ifdef RST_SEQ_TIMEOUT_EN
      wait_cnt      <= '0;
      if (!sys_rst_n) bus.timeout_err <= 1'b0;
`endif
    end else begin
      case (state)
        S_COUNT: begin
          if (cnt == dly_tab[bus.stage_idx]) begin
            bus.rst_out <= bus.rst_out & release_mask;
            cnt         <= '0;
            if (wait_tab[bus.stage_idx]) begin
              state <= S_WAIT;
            end else if (is_last) begin
              state    <= S_DONE;
              bus.done <= 1'b1;
            end else begin
              bus.stage_idx <= bus.stage_idx + 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_WAIT: begin
          if (rdy_tab[bus.stage_idx]) begin
`ifdef RST_SEQ_TIMEOUT_EN
            wait_cnt <= '0;
`endif
            if (is_last) begin
              state    <= S_DONE;
              bus.done <= 1'b1;
            end else begin
              state         <= S_COUNT;
              bus.stage_idx <= bus.stage_idx + 1'b1;
            end
          end
`ifdef RST_SEQ_TIMEOUT_EN
          // Timeout re-arms the whole sequence but leaves the error flag sticky.
          else if (wait_cnt == TIMEOUT) begin
            bus.timeout_err <= 1'b1;
            bus.rst_out     <= '1;
            bus.stage_idx   <= '0;
            cnt             <= '0;
            wait_cnt        <= '0;
            state           <= S_COUNT;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
`endif
        end
        S_DONE: begin
          bus.done <= 1'b1;
        end
        default: begin
          state         <= S_COUNT;
          bus.stage_idx <= '0;
          cnt           <= '0;
          bus.rst_out   <= '1;
          bus.done      <= 1'b0;
`ifdef RST_SEQ_TIMEOUT_EN
          wait_cnt      <= '0;
`endif
        end
      endcase
    end
  end
endmodule

// File: tb/tb_reset_sequencer_multi.sv
// Self-checking bench for reset_sequencer_multi: expected output events are queued per scenario
// and compared edge by edge; edge 0 is the last edge with sys_rst_n low.
`timescale 1ns/1ps
module tb_reset_sequencer_multi;
  localparam int N = 4;

  logic clk10m = 1'b0;
  logic sys_rst_n = 1'b0;
  always #50 clk10m = ~clk10m;

  reset_sequencer_multi_if #(.NUM_STAGES(N)) bus ();
  reset_sequencer_multi_if #(.NUM_STAGES(N)) bus_z ();

  reset_sequencer_multi #(.NUM_STAGES(N)) dut (
    .clk10m   (clk10m),
    .sys_rst_n(sys_rst_n),
    .bus      (bus)
  );

  reset_sequencer_multi #(
    .NUM_STAGES(N),
    .STAGE_DLY ({10'd100, 10'd100, 10'd0, 10'd100})
  ) dut_z (
    .clk10m   (clk10m),
    .sys_rst_n(sys_rst_n),
    .bus      (bus_z)
  );

  typedef struct {
    int         edge_no;
    logic [5:0] val;
  } ev_t;

  ev_t        sb[$];
  int         errors = 0;
  int         checks = 0;
  int         ecnt = 0;
  logic [5:0] prev;
  logic       sel = 1'b0;

  function automatic logic [5:0] mon();
    if (sel) return {bus_z.timeout_err, bus_z.done, bus_z.rst_out};
    return {bus.timeout_err, bus.done, bus.rst_out};
  endfunction

  task automatic push(input int e, input logic tmo, input logic dn, input logic [3:0] r);
    ev_t ev;
    ev.edge_no = e;
    ev.val     = {tmo, dn, r};
    sb.push_back(ev);
  endtask

  task automatic step_to(input int last);
    logic [5:0] cur;
    ev_t        ev;
    while (ecnt < last) begin
      @(posedge clk10m);
      #1;
      ecnt++;
      cur = mon();
      if (sb.size() > 0 && sb[0].edge_no == ecnt) begin
        ev = sb.pop_front();
        checks++;
        if (cur !== ev.val) begin
          errors++;
          $display("FAIL event@%0d {tmo,done,rst_out}: got %b expected %b", ecnt, cur, ev.val);
        end
      end else if (cur !== prev) begin
        checks++;
        errors++;
        $display("FAIL unexpected_change@%0d {tmo,done,rst_out}: got %b expected %b", ecnt, cur, prev);
      end
      prev = cur;
    end
  endtask

  task automatic do_reset(input logic [3:0] rdy);
    sys_rst_n       = 1'b0;
    bus.restart     = 1'b0;
    bus.stage_rdy   = rdy;
    bus_z.restart   = 1'b0;
    bus_z.stage_rdy = 4'hF;
    repeat (2) @(posedge clk10m);
    #1;
    sb.delete();
    ecnt      = 0;
    prev      = 6'b00_1111;
    sys_rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset(4'hF);
    checks++;
    if (bus.rst_out !== 4'hF) begin errors++; $display("FAIL reset_rst_out: got %h expected f", bus.rst_out); end
    checks++;
    if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", bus.done); end
    checks++;
    if (bus.stage_idx !== 2'd0) begin errors++; $display("FAIL reset_stage_idx: got %0d expected 0", bus.stage_idx); end
    checks++;
    if (bus.timeout_err !== 1'b0) begin errors++; $display("FAIL reset_timeout_err: got %b expected 0", bus.timeout_err); end
  endtask

  task automatic test_nominal();
    do_reset(4'hF);
    push(101, 1'b0, 1'b0, 4'hE);
    push(202, 1'b0, 1'b0, 4'hC);
    push(303, 1'b0, 1'b0, 4'h8);
    push(405, 1'b0, 1'b1, 4'h0);
    step_to(420);
    bus.stage_rdy = 4'h0;
    step_to(450);
    checks++;
    if (bus.stage_idx !== 2'd3) begin errors++; $display("FAIL done_stage_idx: got %0d expected 3", bus.stage_idx); end
  endtask

  task automatic test_wait();
    int bad;
    do_reset(4'hB);
    push(101, 1'b0, 1'b0, 4'hE);
    push(202, 1'b0, 1'b0, 4'hC);
    push(303, 1'b0, 1'b0, 4'h8);
    push(601, 1'b0, 1'b1, 4'h0);
    step_to(302);
    bad = 0;
    while (ecnt < 499) begin
      step_to(ecnt + 1);
      if (bus.stage_idx !== 2'd2) bad++;
    end
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL wait_stage_idx: got %0d bad edges expected 0", bad); end
    bus.stage_rdy = 4'hF;
    step_to(500);
    checks++;
    if (bus.stage_idx !== 2'd3) begin errors++; $display("FAIL wait_exit_idx: got %0d expected 3", bus.stage_idx); end
    step_to(620);
  endtask

  task automatic test_restart();
    do_reset(4'hF);
    push(101, 1'b0, 1'b0, 4'hE);
    push(202, 1'b0, 1'b0, 4'hC);
    push(250, 1'b0, 1'b0, 4'hF);
    push(351, 1'b0, 1'b0, 4'hE);
    push(452, 1'b0, 1'b0, 4'hC);
    push(553, 1'b0, 1'b0, 4'h8);
    push(655, 1'b0, 1'b1, 4'h0);
    push(700, 1'b0, 1'b0, 4'hF);
    push(801, 1'b0, 1'b0, 4'hE);
    step_to(249);
    bus.restart = 1'b1;
    step_to(250);
    bus.restart = 1'b0;
    step_to(699);
    bus.restart = 1'b1;
    step_to(700);
    bus.restart = 1'b0;
    step_to(810);
  endtask

  task automatic test_back_to_back();
    do_reset(4'hB);
    push(101, 1'b0, 1'b0, 4'hF);
    push(202, 1'b0, 1'b0, 4'hE);
    push(303, 1'b0, 1'b0, 4'hC);
    push(404, 1'b0, 1'b0, 4'h8);
    push(450, 1'b0, 1'b0, 4'hF);
    push(551, 1'b0, 1'b0, 4'hE);
    push(652, 1'b0, 1'b0, 4'hC);
    push(753, 1'b0, 1'b0, 4'h8);
    push(855, 1'b0, 1'b1, 4'h0);
    step_to(100);
    bus.restart = 1'b1;
    step_to(101);
    bus.restart = 1'b0;
    step_to(449);
    bus.restart   = 1'b1;
    bus.stage_rdy = 4'hF;
    step_to(450);
    bus.restart = 1'b0;
    step_to(860);
  endtask

  task automatic test_timeout();
    do_reset(4'h0);
    push(101, 1'b0, 1'b0, 4'hE);
    push(202, 1'b0, 1'b0, 4'hC);
    push(303, 1'b0, 1'b0, 4'h8);
`ifdef RST_SEQ_TIMEOUT_EN
    push(1304, 1'b1, 1'b0, 4'hF);
    push(1405, 1'b1, 1'b0, 4'hE);
    step_to(1420);
    checks++;
    if (bus.stage_idx !== 2'd1) begin errors++; $display("FAIL timeout_rerun_idx: got %0d expected 1", bus.stage_idx); end
`else
    step_to(1500);
    checks++;
    if (bus.timeout_err !== 1'b0) begin errors++; $display("FAIL no_timeout_err: got %b expected 0", bus.timeout_err); end
    checks++;
    if (bus.stage_idx !== 2'd2) begin errors++; $display("FAIL wait_persist_idx: got %0d expected 2", bus.stage_idx); end
`endif
  endtask

  task automatic test_zero_delay();
    sel = 1'b1;
    do_reset(4'hF);
    push(101, 1'b0, 1'b0, 4'hE);
    push(102, 1'b0, 1'b0, 4'hC);
    push(203, 1'b0, 1'b0, 4'h8);
    push(305, 1'b0, 1'b1, 4'h0);
    step_to(320);
    sel = 1'b0;
  endtask

  task automatic test_reset_mid();
    do_reset(4'hF);
    push(101, 1'b0, 1'b0, 4'hE);
    push(150, 1'b0, 1'b0, 4'hF);
    push(252, 1'b0, 1'b0, 4'hE);
    step_to(149);
    sys_rst_n = 1'b0;
    step_to(151);
    checks++;
    if (bus.stage_idx !== 2'd0) begin errors++; $display("FAIL mid_reset_idx: got %0d expected 0", bus.stage_idx); end
    sys_rst_n = 1'b1;
    step_to(260);
  endtask

  initial begin
    bus.restart     = 1'b0;
    bus.stage_rdy   = 4'hF;
    bus_z.restart   = 1'b0;
    bus_z.stage_rdy = 4'hF;
    test_reset();
    test_nominal();
    test_wait();
    test_restart();
    test_back_to_back();
    test_timeout();
    test_zero_delay();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/reset_sequencer_multi.md
RESET_SEQUENCER_MULTI -- requirements
Module: reset_sequencer_multi

Interface
REQ-001 Parameter NUM_STAGES, 4, number of sequenced reset outputs (1..16).
REQ-002 Parameter CNT_W, 10, width of the per-stage delay counter.
REQ-003 Parameter STAGE_DLY, {4{10'd100}}, packed NUM_STAGES*CNT_W vector; slice i holds stage i hold count DLY[i].
REQ-004 Parameter WAIT_RDY, 4'b0100, bit i set means wait for stage_rdy[i] after releasing stage i.
REQ-005 Parameter TIMEOUT, 1000, ready-wait limit in cycles (used only with RST_SEQ_TIMEOUT_EN); width 16.
REQ-006 clk10m  input  1  sole clock; all logic on its rising edge.
REQ-007 sys_rst_n  input  1  reset; synchronous and active-low.
REQ-008 restart  input  1  single-cycle request to rerun the full sequence.
REQ-009 stage_rdy  input  NUM_STAGES  per-stage ready (e.g. IDELAYCTRL RDY); only bits with WAIT_RDY set are sampled.
REQ-010 rst_out  output  NUM_STAGES  active-high reset for stage i, released in ascending index order.
REQ-011 stage_idx  output  clog2(NUM_STAGES) (min 1)  stage currently being counted or waited on.
REQ-012 done  output  1  high once all stages are released.
REQ-013 timeout_err  output  1  sticky ready-wait timeout flag.

Function
REQ-014 The FSM SHALL have states COUNT, WAIT and DONE; it is registered with no combinational outputs.
REQ-015 In COUNT for stage i, cnt SHALL increment each cycle while cnt != DLY[i].
REQ-016 On the edge where cnt == DLY[i], rst_out[i] SHALL go to 0 and cnt SHALL clear. The next state SHALL be WAIT if WAIT_RDY[i] is set, else DONE if i == NUM_STAGES-1, else COUNT with stage i+1.
REQ-017 Each non-waiting stage SHALL therefore take DLY[i]+1 cycles; DLY[i]=0 SHALL release on the first edge in COUNT.
REQ-018 WAIT SHALL last at least one cycle. On an edge where stage_rdy[i]=1, the FSM SHALL go to COUNT stage i+1, or to DONE if i is the last stage.
REQ-019 The transition into DONE SHALL set done=1 on the same edge as the last rst_out release; DONE SHALL hold with stage_rdy ignored.
REQ-020 restart=1 in any state SHALL, on that edge, set all rst_out=1 and done=0, clear cnt, and enter COUNT stage 0. Restart wins over a simultaneous release or ready.
REQ-021 Released resets SHALL never re-assert except via restart, timeout or sys_rst_n.
REQ-022 An illegal state or stage index SHALL recover to the reset state on the next edge.

Reset
REQ-023 On an edge with sys_rst_n=0, the block SHALL set rst_out=all ones, done=0, timeout_err=0, cnt=0, wait counter=0, state=COUNT and stage_idx=0.
REQ-024 The first edge with sys_rst_n=1 SHALL count as count cycle 1 of stage 0.
REQ-025 Reset asserted mid-sequence SHALL override every other input.

Configuration
REQ-026 The macro RST_SEQ_TIMEOUT_EN SHALL control the ready-wait timeout.
REQ-027 With RST_SEQ_TIMEOUT_EN defined, a 16-bit wait counter SHALL increment in WAIT. If it equals TIMEOUT with stage_rdy[i]=0, that edge SHALL set timeout_err=1, all rst_out=1 and state COUNT stage 0. If ready and timeout coincide, ready wins. timeout_err SHALL clear only on sys_rst_n.
REQ-028 Without RST_SEQ_TIMEOUT_EN, WAIT SHALL persist indefinitely, timeout_err SHALL be tied to 0 and no wait counter SHALL exist.

Verification
REQ-029 Defaults, stage_rdy=4'hF, reset released at edge 0 -> rst_out[0] falls at edge 101, [1] at 202, [2] at 303, [3] and done at 405.
REQ-030 Defaults, stage_rdy[2] rises at edge 500 -> rst_out[3] and done at edge 601; stage_idx=2 throughout edges 303-500.
REQ-031 restart pulsed at edge 250 -> rst_out=4'hF and done=0 at edge 250, then rst_out[0] falls at edge 351.
REQ-032 With RST_SEQ_TIMEOUT_EN, stage_rdy=0 -> timeout_err=1 and rst_out=4'hF at edge 1304, then rst_out[0] falls at edge 1405.
REQ-033 STAGE_DLY slice 1 = 0 -> rst_out[1] falls one edge after rst_out[0] (edges 101 and 102).
REQ-034 sys_rst_n low at edge 150 for 2 cycles -> all outputs at reset values, and the sequence restarts from stage 0 after release.
